// File: rtl/peak_result_streamer_pkg.sv
// Shared constants for the histogram builder / peak detector and the peak result streamer.
// The streamer FSM state encoding is defined here too.
package peak_result_streamer_pkg;

    localparam int NP        = 12;
    localparam int NB        = 64;
    localparam int PIXEL_NUM = 4;
    localparam int PIX_W     = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
    localparam int FID_W     = 4;
    localparam int DROP_W    = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_e;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

endpackage

// File: rtl/peak_result_streamer_result_slot.sv
// One frame buffer: packed peak-time vector, frame id and valid bit.
// The load control has priority over clear.
module peak_result_streamer_result_slot #(
    parameter int W     = 48,
    parameter int FID_W = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic             clear,
    input  logic [W-1:0]     load_data,
    input  logic [FID_W-1:0] load_id,
    output logic [W-1:0]     data,
    output logic             valid,
    output logic [FID_W-1:0] id
);
    import peak_result_streamer_pkg::*;

    logic [W-1:0]     data_r;
    logic             valid_r;
    logic [FID_W-1:0] id_r;

    // Slot storage with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!res) begin
            data_r  <= {W{1'b0}};
            valid_r <= 1'b0;
            id_r    <= {FID_W{1'b0}};
        end else if (load) begin
            data_r  <= load_data;
            valid_r <= 1'b1;
            id_r    <= load_id;
        end else if (clear) begin
            data_r  <= {W{1'b0}};
            valid_r <= 1'b0;
            id_r    <= {FID_W{1'b0}};
        end else begin
            data_r  <= data_r;
            valid_r <= valid_r;
            id_r    <= id_r;
        end
    end

    assign data  = data_r;
    assign valid = valid_r;
    assign id    = id_r;

endmodule

// File: rtl/peak_result_streamer.sv
// Captures the per-pixel peak-time vector at frame end and streams it one pixel per beat.
// Active plus pending slot let one frame arrive while the previous one drains.
module peak_result_streamer #(
    parameter int NP        = peak_result_streamer_pkg::NP,
    parameter int PIXEL_NUM = peak_result_streamer_pkg::PIXEL_NUM,
    parameter int PIX_W     = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1,
    parameter int FID_W     = peak_result_streamer_pkg::FID_W,
    parameter int DROP_W    = peak_result_streamer_pkg::DROP_W
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic [NP*PIXEL_NUM-1:0] result_in,
    input  logic                    frame_done,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [NP-1:0]           m_data,
    output logic [PIX_W-1:0]        m_pix,
    output logic                    m_sof,
    output logic                    m_eof,
    output logic                    m_nohit,
    output logic [FID_W-1:0]        m_fid,
    output logic                    busy,
    output logic                    overrun,
    output logic [DROP_W-1:0]       drop_cnt
);
    import peak_result_streamer_pkg::*;

    localparam int DW = NP * PIXEL_NUM;

    logic [0:0]        state_r;
    logic [0:0]        state_nxt_s;
    logic [PIX_W-1:0]  idx_r;
    logic [PIX_W-1:0]  idx_nxt_s;
    logic [FID_W-1:0]  fid_r;
    logic              overrun_r;
    logic [DROP_W-1:0] drop_cnt_r;

    logic              act_load_s;
    logic              act_clear_s;
    logic [DW-1:0]     act_src_s;
    logic [FID_W-1:0]  act_src_id_s;
    logic [DW-1:0]     act_data_s;
    logic              act_valid_s;
    logic [FID_W-1:0]  act_id_s;
    logic              pend_load_s;
    logic              pend_clear_s;
    logic [DW-1:0]     pend_data_s;
    logic              pend_valid_s;
    logic [FID_W-1:0]  pend_id_s;

    logic              stream_s;
    logic              hs_s;
    logic              last_hs_s;
    logic              drop_s;
    logic [DW-1:0]     act_data_nxt_s;
    logic [FID_W-1:0]  act_id_nxt_s;
    logic              pend_valid_nxt_s;
    logic [NP-1:0]     pix_nxt_s;

    logic              m_valid_r;
    logic [NP-1:0]     m_data_r;
    logic [PIX_W-1:0]  m_pix_r;
    logic              m_sof_r;
    logic              m_eof_r;
    logic              m_nohit_r;
    logic [FID_W-1:0]  m_fid_r;
    logic              busy_r;

    function automatic logic [NP-1:0] pick_pixel(input logic [DW-1:0] vec,
                                                 input logic [PIX_W-1:0] sel);
        logic [NP-1:0] r;
        r = {NP{1'b0}};
        for (int i = 0; i < PIXEL_NUM; i++) begin
            r = (sel == PIX_W'(i)) ? vec[i*NP +: NP] : r;
        end
        return r;
    endfunction

    peak_result_streamer_result_slot #(.W(DW), .FID_W(FID_W)) u_active (
        .clk       (clk),
        .res       (res),
        .load      (act_load_s),
        .clear     (act_clear_s),
        .load_data (act_src_s),
        .load_id   (act_src_id_s),
        .data      (act_data_s),
        .valid     (act_valid_s),
        .id        (act_id_s)
    );

    peak_result_streamer_result_slot #(.W(DW), .FID_W(FID_W)) u_pending (
        .clk       (clk),
        .res       (res),
        .load      (pend_load_s),
        .clear     (pend_clear_s),
        .load_data (result_in),
        .load_id   (fid_r),
        .data      (pend_data_s),
        .valid     (pend_valid_s),
        .id        (pend_id_s)
    );

    assign stream_s  = (state_r == ST_STREAM) && act_valid_s;
    assign hs_s      = stream_s && m_ready;
    assign last_hs_s = hs_s && (idx_r == PIX_W'(PIXEL_NUM - 1));

    // Next-state decode: slot moves, index advance and frame drop decision
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        act_load_s   = 1'b0;
        act_clear_s  = 1'b0;
        act_src_s    = result_in;
        act_src_id_s = fid_r;
        pend_load_s  = 1'b0;
        pend_clear_s = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_done) begin
                    act_load_s  = 1'b1;
                    idx_nxt_s   = {PIX_W{1'b0}};
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (last_hs_s) begin
                    idx_nxt_s = {PIX_W{1'b0}};
                    if (pend_valid_s) begin
                        act_load_s   = 1'b1;
                        act_src_s    = pend_data_s;
                        act_src_id_s = pend_id_s;
                        // The freed pending slot takes a coincident frame directly
                        if (frame_done) begin
                            pend_load_s = 1'b1;
                        end else begin
                            pend_clear_s = 1'b1;
                        end
                    end else if (frame_done) begin
                        act_load_s = 1'b1;
                    end else begin
                        act_clear_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    if (hs_s) begin
                        idx_nxt_s = idx_r + PIX_W'(1);
                    end else begin
                        idx_nxt_s = idx_r;
                    end
                    if (frame_done && !pend_valid_s) begin
                        pend_load_s = 1'b1;
                    end else if (frame_done) begin
                        drop_s = 1'b1;
                    end else begin
                        pend_load_s = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                idx_nxt_s    = {PIX_W{1'b0}};
                act_clear_s  = 1'b1;
                pend_clear_s = 1'b1;
            end
        endcase
    end

    // Post-edge view of the slots, so outputs can be registered with no bubble
    always_comb begin
        if (act_load_s) begin
            act_data_nxt_s = act_src_s;
            act_id_nxt_s   = act_src_id_s;
        end else begin
            act_data_nxt_s = act_data_s;
            act_id_nxt_s   = act_id_s;
        end
        if (pend_load_s) begin
            pend_valid_nxt_s = 1'b1;
        end else if (pend_clear_s) begin
            pend_valid_nxt_s = 1'b0;
        end else begin
            pend_valid_nxt_s = pend_valid_s;
        end
    end

    assign pix_nxt_s = pick_pixel(act_data_nxt_s, idx_nxt_s);

    // Control state, frame id counter and drop bookkeeping
    always_ff @(posedge clk) begin
        if (!res) begin
            state_r    <= ST_IDLE;
            idx_r      <= {PIX_W{1'b0}};
            fid_r      <= {FID_W{1'b0}};
            overrun_r  <= 1'b0;
            drop_cnt_r <= {DROP_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            // Dropped frames still consume an id so gaps reveal them downstream
            if (frame_done) begin
                fid_r <= fid_r + FID_W'(1);
            end else begin
                fid_r <= fid_r;
            end
            if (drop_s) begin
                overrun_r  <= 1'b1;
                drop_cnt_r <= (drop_cnt_r == {DROP_W{1'b1}}) ? drop_cnt_r
                                                             : drop_cnt_r + DROP_W'(1);
            end else begin
                overrun_r  <= overrun_r;
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    // Registered stream outputs, zeroed whenever no beat is offered
    always_ff @(posedge clk) begin
        if (!res) begin
            m_valid_r <= 1'b0;
            m_data_r  <= {NP{1'b0}};
            m_pix_r   <= {PIX_W{1'b0}};
            m_sof_r   <= 1'b0;
            m_eof_r   <= 1'b0;
            m_nohit_r <= 1'b0;
            m_fid_r   <= {FID_W{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == ST_STREAM) || pend_valid_nxt_s;
            if (state_nxt_s == ST_STREAM) begin
                m_valid_r <= 1'b1;
                m_data_r  <= pix_nxt_s;
                m_pix_r   <= idx_nxt_s;
                m_sof_r   <= (idx_nxt_s == {PIX_W{1'b0}});
                m_eof_r   <= (idx_nxt_s == PIX_W'(PIXEL_NUM - 1));
                m_nohit_r <= (pix_nxt_s == {NP{1'b0}});
                m_fid_r   <= act_id_nxt_s;
            end else begin
                m_valid_r <= 1'b0;
                m_data_r  <= {NP{1'b0}};
                m_pix_r   <= {PIX_W{1'b0}};
                m_sof_r   <= 1'b0;
                m_eof_r   <= 1'b0;
                m_nohit_r <= 1'b0;
                m_fid_r   <= {FID_W{1'b0}};
            end
        end
    end

    assign m_valid  = m_valid_r;
    assign m_data   = m_data_r;
    assign m_pix    = m_pix_r;
    assign m_sof    = m_sof_r;
    assign m_eof    = m_eof_r;
    assign m_nohit  = m_nohit_r;
    assign m_fid    = m_fid_r;
    assign busy     = busy_r;
    assign overrun  = overrun_r;
    assign drop_cnt = drop_cnt_r;

endmodule
